amber48_wb_queue: RTL and testbench
===================================

Name: amber48_wb_queue

Overview:
Writeback-side initiator for the amber48 register file's single write port. It accepts results from two producers (ALU and load/store unit), buffers them in a small in-order queue, and issues one regfile write per cycle. It also provides read-bypass data for pending writes, so the decode stage sees the youngest not-yet-committed value of a register.

Parameters:
- DEPTH, 4, queue entries; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridable.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- alu_valid_i  in  1  ALU result valid
- alu_ready_o  out  1  ALU result accepted this cycle
- alu_addr_i  in  REG_ADDR_WIDTH  ALU destination register
- alu_data_i  in  XLEN  ALU result
- lsu_valid_i  in  1  load result valid
- lsu_ready_o  out  1  load result accepted this cycle
- lsu_addr_i  in  REG_ADDR_WIDTH  load destination register
- lsu_data_i  in  XLEN  load data
- drain_en_i  in  1  permits the head entry to be written this cycle
- we_o  out  1  regfile write enable
- addr_w_o  out  REG_ADDR_WIDTH  regfile write address
- wd_o  out  XLEN  regfile write data
- rs_a_i, rs_b_i  in  REG_ADDR_WIDTH  decode read addresses
- fwd_a_hit_o, fwd_b_hit_o  out  1  pending write matches rs_x
- fwd_a_data_o, fwd_b_data_o  out  XLEN  youngest matching pending data
- count_o  out  PTR_W+1  occupied entries
- full_o, empty_o  out  1  count==DEPTH, count==0

Behaviour:
- Reset (asynchronous, rst_ni low): head, tail and count are 0 and all entry valid bits are clear; we_o=0, empty_o=1, full_o=0, fwd hits 0. Pending entries are discarded with no write issued, including when reset arrives mid-drain.
- Handshake: a transfer occurs on a clock edge where valid and ready are both high. Producers hold addr/data stable while valid && !ready.
- Ready rules use occupancy only, with no credit for a same-cycle pop, which keeps ready off the drain path:
  - free = DEPTH - count.
  - alu_ready_o = free >= 1.
  - lsu_ready_o = free >= (alu_valid_i && alu_addr_i!=0 ? 2 : 1).
- Writes to r0: always ready (no slot needed) and silently dropped; never enqueued.
- Enqueue order when both transfer in the same cycle: the ALU entry is written at tail and the LSU entry at tail+1. The LSU entry is therefore younger. Pointers wrap modulo DEPTH.
- Drain:
  - we_o = !empty && drain_en_i, combinational from the head entry.
  - addr_w_o and wd_o always show the head entry, and are 0 when empty.
  - Pop on the same edge as the write.
  - Latency: an entry accepted at edge N is written at edge N+1 at the earliest.
- count update: count_next = count + pushes - pop. Simultaneous push and pop at full or at empty is legal.
  - At full, ready is low, so only a pop occurs.
  - At empty, a push does not pop in the same cycle because the entry is not yet visible.
- Bypass:
  - Compare rs_x_i against every valid entry; hit when any entry matches and rs_x_i != 0.
  - Data comes from the youngest match, i.e. the entry nearest tail.
  - Incoming same-cycle writes are not considered.
  - The head entry being written this cycle still reports a hit, consistent with the regfile value after the edge.
- No state machine beyond the queue; the queue does not need a separate state.

Decomposition:
- amber48_pkg already holds XLEN and REG_ADDR_WIDTH.
- Add to amber48_pkg: typedef amber48_wb_entry_s {valid, addr, data}.
- Add to amber48_pkg: typedef amber48_wb_req_s {valid, addr, data} for producer ports in future revisions.
- One sub-module is natural: amber48_wb_fwd_lookup. It is a combinational youngest-match priority search, instantiated twice (ports a and b) and parameterised on DEPTH.

Test Plan:
1. Reset with 3 pending entries and drain_en_i=0, then release -> count_o=0, empty_o=1, we_o=0, and no write issued.
2. Single ALU push r5=0x0000_1234_5678 at edge N with drain_en_i=1 -> we_o=1, addr_w_o=5, wd_o=0x0000_1234_5678 in cycle N+1; empty_o=1 after edge N+1.
3. ALU r3=0xA and LSU r3=0xB in the same cycle, drain_en_i=0 -> count_o=2 and rs_a_i=3 gives fwd_a_hit_o=1, fwd_a_data_o=0xB. After enabling drain, writes occur in order 0xA then 0xB.
4. drain_en_i=0; fill to DEPTH=4 -> full_o=1, both readies 0. With count=3 and both producers valid (non-zero addresses) -> alu_ready_o=1, lsu_ready_o=0.
5. ALU push to r0 with data 0xFF -> alu_ready_o=1, count_o unchanged, no write issued, and rs_a_i=0 gives fwd_a_hit_o=0.
6. Pointer wrap: 10 back-to-back ALU pushes r1..r10 with drain_en_i=1 -> 10 writes issued in order with matching data, and count_o never exceeds 1.

Source files
------------

// File: rtl/amber48_pkg.sv
// Shared amber48 core constants and writeback queue data types.
package amber48_pkg;

    localparam int unsigned XLEN           = 48;
    localparam int unsigned REG_ADDR_WIDTH = 5;

    typedef struct packed {
        logic                      valid;
        logic [REG_ADDR_WIDTH-1:0] addr;
        logic [XLEN-1:0]           data;
    } amber48_wb_entry_s;

    typedef struct packed {
        logic                      valid;
        logic [REG_ADDR_WIDTH-1:0] addr;
        logic [XLEN-1:0]           data;
    } amber48_wb_req_s;

endpackage

// File: rtl/amber48_wb_fwd_lookup.sv
// Youngest-match search over the writeback queue for one decode read port.
module amber48_wb_fwd_lookup
    import amber48_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic [PTR_W-1:0]          head_i,
    input  amber48_wb_entry_s         entries_i [DEPTH],
    input  logic [REG_ADDR_WIDTH-1:0] rs_i,
    output logic                      hit_o,
    output logic [XLEN-1:0]           data_o
);

    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_i + PTR_W'(i);
            if (entries_i[idx].valid && (entries_i[idx].addr == rs_i) && (rs_i != '0)) begin
                hit_o  = 1'b1;
                data_o = entries_i[idx].data;
            end
        end
    end

endmodule

// File: rtl/amber48_wb_queue.sv
// Writeback queue: merges ALU and LSU results into the single regfile write port,
// with bypass of pending writes to the decode stage.
module amber48_wb_queue
    import amber48_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      alu_valid_i,
    output logic                      alu_ready_o,
    input  logic [REG_ADDR_WIDTH-1:0] alu_addr_i,
    input  logic [XLEN-1:0]           alu_data_i,
    input  logic                      lsu_valid_i,
    output logic                      lsu_ready_o,
    input  logic [REG_ADDR_WIDTH-1:0] lsu_addr_i,
    input  logic [XLEN-1:0]           lsu_data_i,
    input  logic                      drain_en_i,
    output logic                      we_o,
    output logic [REG_ADDR_WIDTH-1:0] addr_w_o,
    output logic [XLEN-1:0]           wd_o,
    input  logic [REG_ADDR_WIDTH-1:0] rs_a_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs_b_i,
    output logic                      fwd_a_hit_o,
    output logic                      fwd_b_hit_o,
    output logic [XLEN-1:0]           fwd_a_data_o,
    output logic [XLEN-1:0]           fwd_b_data_o,
    output logic [PTR_W:0]            count_o,
    output logic                      full_o,
    output logic                      empty_o
);

    amber48_wb_entry_s entries_q [DEPTH];
    logic [PTR_W-1:0]  head_q, tail_q;
    logic [PTR_W:0]    count_q;

    logic [PTR_W:0]    free;
    logic [PTR_W:0]    lsu_need;
    logic              alu_nz, lsu_nz;
    logic              alu_push, lsu_push, pop;
    logic [PTR_W-1:0]  lsu_slot;
    logic [1:0]        n_push;

    assign alu_nz = (alu_addr_i != '0);
    assign lsu_nz = (lsu_addr_i != '0);

    // Readiness depends on occupancy only; a same-cycle pop earns no credit.
    assign free        = (PTR_W+1)'(DEPTH) - count_q;
    assign lsu_need    = (alu_valid_i && alu_nz) ? (PTR_W+1)'(2) : (PTR_W+1)'(1);
    assign alu_ready_o = !alu_nz || (free >= (PTR_W+1)'(1));
    assign lsu_ready_o = !lsu_nz || (free >= lsu_need);

    // r0 writes complete the handshake but never occupy a slot.
    assign alu_push = alu_valid_i && alu_ready_o && alu_nz;
    assign lsu_push = lsu_valid_i && lsu_ready_o && lsu_nz;
    assign lsu_slot = alu_push ? tail_q + PTR_W'(1) : tail_q;
    assign n_push   = {1'b0, alu_push} + {1'b0, lsu_push};

    assign empty_o  = (count_q == '0);
    assign full_o   = (count_q == (PTR_W+1)'(DEPTH));
    assign count_o  = count_q;
    assign pop      = !empty_o && drain_en_i;
    assign we_o     = pop;
    assign addr_w_o = empty_o ? '0 : entries_q[head_q].addr;
    assign wd_o     = empty_o ? '0 : entries_q[head_q].data;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            if (pop) begin
                entries_q[head_q].valid <= 1'b0;
                head_q                  <= head_q + PTR_W'(1);
            end
            if (alu_push) begin
                entries_q[tail_q] <= '{valid: 1'b1, addr: alu_addr_i, data: alu_data_i};
            end
            if (lsu_push) begin
                entries_q[lsu_slot] <= '{valid: 1'b1, addr: lsu_addr_i, data: lsu_data_i};
            end
            tail_q  <= tail_q + PTR_W'(n_push);
            count_q <= count_q + (PTR_W+1)'(n_push) - (PTR_W+1)'(pop);
        end
    end

    amber48_wb_fwd_lookup #(.DEPTH(DEPTH)) u_fwd_a (
        .head_i    (head_q),
        .entries_i (entries_q),
        .rs_i      (rs_a_i),
        .hit_o     (fwd_a_hit_o),
        .data_o    (fwd_a_data_o)
    );

    amber48_wb_fwd_lookup #(.DEPTH(DEPTH)) u_fwd_b (
        .head_i    (head_q),
        .entries_i (entries_q),
        .rs_i      (rs_b_i),
        .hit_o     (fwd_b_hit_o),
        .data_o    (fwd_b_data_o)
    );

endmodule

// File: tb/tb_amber48_wb_queue.sv
// Directed bench for amber48_wb_queue; regfile writes are checked against a scoreboard queue.
module tb_amber48_wb_queue;
    import amber48_pkg::*;

    typedef struct {
        logic [REG_ADDR_WIDTH-1:0] addr;
        logic [XLEN-1:0]           data;
    } wr_t;

    logic                      clk_i = 1'b0;
    logic                      rst_ni;
    logic                      alu_valid_i, lsu_valid_i, drain_en_i;
    logic                      alu_ready_o, lsu_ready_o;
    logic [REG_ADDR_WIDTH-1:0] alu_addr_i, lsu_addr_i, rs_a_i, rs_b_i, addr_w_o;
    logic [XLEN-1:0]           alu_data_i, lsu_data_i, wd_o, fwd_a_data_o, fwd_b_data_o;
    logic                      we_o, fwd_a_hit_o, fwd_b_hit_o, full_o, empty_o;
    logic [2:0]                count_o;

    int  checks = 0;
    int  errors = 0;
    wr_t exp_q[$];

    amber48_wb_queue #(.DEPTH(4)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .alu_valid_i  (alu_valid_i),
        .alu_ready_o  (alu_ready_o),
        .alu_addr_i   (alu_addr_i),
        .alu_data_i   (alu_data_i),
        .lsu_valid_i  (lsu_valid_i),
        .lsu_ready_o  (lsu_ready_o),
        .lsu_addr_i   (lsu_addr_i),
        .lsu_data_i   (lsu_data_i),
        .drain_en_i   (drain_en_i),
        .we_o         (we_o),
        .addr_w_o     (addr_w_o),
        .wd_o         (wd_o),
        .rs_a_i       (rs_a_i),
        .rs_b_i       (rs_b_i),
        .fwd_a_hit_o  (fwd_a_hit_o),
        .fwd_b_hit_o  (fwd_b_hit_o),
        .fwd_a_data_o (fwd_a_data_o),
        .fwd_b_data_o (fwd_b_data_o),
        .count_o      (count_o),
        .full_o       (full_o),
        .empty_o      (empty_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic mid();
        @(negedge clk_i);
    endtask

    task automatic expect_wr(input logic [REG_ADDR_WIDTH-1:0] a, input logic [XLEN-1:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic wait_empty(input string name);
        for (int i = 0; i < 20 && !empty_o; i++) cyc();
        mid();
        chk(name, 64'(empty_o), 64'd1);
    endtask

    // Every write the DUT presents must match the oldest outstanding expectation.
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1 && we_o === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%0d data=%h exp=none", addr_w_o, wd_o);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                if (addr_w_o !== w.addr || wd_o !== w.data) begin
                    errors++;
                    $display("FAIL write_order got=%0d:%h exp=%0d:%h", addr_w_o, wd_o, w.addr, w.data);
                end
            end
        end
    end

    initial begin
        rst_ni = 1'b0;
        alu_valid_i = 1'b0; lsu_valid_i = 1'b0; drain_en_i = 1'b0;
        alu_addr_i = '0; lsu_addr_i = '0; alu_data_i = '0; lsu_data_i = '0;
        rs_a_i = '0; rs_b_i = '0;
        cyc(); cyc();
        rst_ni = 1'b1;

        // 1: reset discards pending entries, including with drain requested
        alu_valid_i = 1'b1; alu_addr_i = 5'd7; alu_data_i = 48'h77;
        cyc(); alu_addr_i = 5'd8; alu_data_i = 48'h88;
        cyc(); alu_addr_i = 5'd9; alu_data_i = 48'h99;
        cyc(); alu_valid_i = 1'b0;
        mid();
        chk("pre_reset_count", 64'(count_o), 64'd3);
        #2 rst_ni = 1'b0; drain_en_i = 1'b1; rs_a_i = 5'd7;
        mid();
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_empty", 64'(empty_o), 64'd1);
        chk("rst_full", 64'(full_o), 64'd0);
        chk("rst_we", 64'(we_o), 64'd0);
        chk("rst_hit", 64'(fwd_a_hit_o), 64'd0);
        chk("rst_wd", 64'(wd_o), 64'd0);
        cyc();
        drain_en_i = 1'b0; rst_ni = 1'b1;
        mid();
        chk("post_rst_count", 64'(count_o), 64'd0);
        chk("post_rst_we", 64'(we_o), 64'd0);

        // 2: single ALU push appears as a write the following cycle
        cyc();
        drain_en_i = 1'b1;
        alu_valid_i = 1'b1; alu_addr_i = 5'd5; alu_data_i = 48'h0000_1234_5678;
        expect_wr(5'd5, 48'h0000_1234_5678);
        cyc(); alu_valid_i = 1'b0;
        mid();
        chk("single_we", 64'(we_o), 64'd1);
        chk("single_addr", 64'(addr_w_o), 64'd5);
        chk("single_wd", 64'(wd_o), 64'h0000_1234_5678);
        cyc();
        mid();
        chk("single_empty", 64'(empty_o), 64'd1);

        // 3: same-cycle ALU+LSU to r3, LSU is the younger
        cyc();
        drain_en_i = 1'b0;
        alu_valid_i = 1'b1; alu_addr_i = 5'd3; alu_data_i = 48'hA;
        lsu_valid_i = 1'b1; lsu_addr_i = 5'd3; lsu_data_i = 48'hB;
        expect_wr(5'd3, 48'hA);
        expect_wr(5'd3, 48'hB);
        mid();
        chk("dual_alu_rdy", 64'(alu_ready_o), 64'd1);
        chk("dual_lsu_rdy", 64'(lsu_ready_o), 64'd1);
        cyc();
        alu_valid_i = 1'b0; lsu_valid_i = 1'b0; rs_a_i = 5'd3; rs_b_i = 5'd4;
        mid();
        chk("dual_count", 64'(count_o), 64'd2);
        chk("dual_hit", 64'(fwd_a_hit_o), 64'd1);
        chk("dual_fwd", 64'(fwd_a_data_o), 64'hB);
        chk("dual_b_miss", 64'(fwd_b_hit_o), 64'd0);
        cyc();
        drain_en_i = 1'b1;
        wait_empty("dual_drain");

        // 4: fill to full, ready arbitration at count 3 and 4
        cyc();
        drain_en_i = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            alu_valid_i = 1'b1; alu_addr_i = 5'(i); alu_data_i = 48'(16 + i);
            expect_wr(5'(i), 48'(16 + i));
            cyc();
        end
        alu_addr_i = 5'd4; alu_data_i = 48'h14;
        lsu_valid_i = 1'b1; lsu_addr_i = 5'd5; lsu_data_i = 48'h15;
        expect_wr(5'd4, 48'h14);
        mid();
        chk("c3_count", 64'(count_o), 64'd3);
        chk("c3_alu_rdy", 64'(alu_ready_o), 64'd1);
        chk("c3_lsu_rdy", 64'(lsu_ready_o), 64'd0);
        cyc();
        alu_valid_i = 1'b0;
        mid();
        chk("full_flag", 64'(full_o), 64'd1);
        chk("full_count", 64'(count_o), 64'd4);
        chk("full_alu_rdy", 64'(alu_ready_o), 64'd0);
        chk("full_lsu_rdy", 64'(lsu_ready_o), 64'd0);
        cyc();
        lsu_valid_i = 1'b0; drain_en_i = 1'b1;
        wait_empty("full_drain");

        // 5: r0 write is accepted and dropped
        cyc();
        alu_valid_i = 1'b1; alu_addr_i = 5'd0; alu_data_i = 48'hFF; rs_a_i = 5'd0;
        mid();
        chk("r0_rdy", 64'(alu_ready_o), 64'd1);
        cyc();
        alu_valid_i = 1'b0;
        mid();
        chk("r0_count", 64'(count_o), 64'd0);
        chk("r0_we", 64'(we_o), 64'd0);
        chk("r0_hit", 64'(fwd_a_hit_o), 64'd0);

        // 6: back-to-back pushes with drain wrap the pointers
        cyc();
        for (int i = 1; i <= 10; i++) begin
            alu_valid_i = 1'b1; alu_addr_i = 5'(i); alu_data_i = 48'(256 + i);
            expect_wr(5'(i), 48'(256 + i));
            cyc();
            mid();
            chk("wrap_count_le1", 64'(count_o <= 3'd1), 64'd1);
            #2;
        end
        alu_valid_i = 1'b0;
        wait_empty("wrap_drain");
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
